normalizer: RTL and testbench
=============================

# normalizer

Iterative left-normalizer: shifts a loaded N-bit value left one bit per clock until its MSB is 1. It reports the number of shifts taken, which is the leading-zero count. It is the inverse companion of the iterative shifter: the shifter applies a known shift count, and this block recovers the count from a shifted value. It sits beside the shifter in the datapath and uses the same start/finished handshake, so a controller can drive either block identically.

## Interface
- N, default 8, data width; also the width of the count output.
- i_clock  input  1  sole clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  load i_value and begin normalizing; sampled on rising edge.
- i_value  input  N  value to normalize; sampled only on the edge where i_start is sampled high.
- o_busy  output  1  high while in SHIFT.
- o_finished  output  1  high while in DONE; stays high until the next accepted start or reset.
- o_value  output  N  normalized value (MSB = 1 unless zero); registered.
- o_count  output  N  number of left shifts performed, range 0..N-1; registered.
- o_zero  output  1  high in DONE when the loaded value was 0.

## Operation
- States:
  - IDLE: reset state.
  - SHIFT: normalizing.
  - DONE: result valid.
- IDLE or DONE with i_start=1: load working reg <= i_value, count <= 0, o_zero <= 0, go to SHIFT.
- IDLE with i_start=0: stay in IDLE.
- DONE with i_start=0: stay in DONE; hold o_value, o_count and o_zero.
- SHIFT, each edge:
  - If working reg == 0: go to DONE, set o_zero=1, o_value=0, o_count=0. No shifting.
  - Else if working reg[N-1] == 1: go to DONE; o_value = working reg, o_count = count.
  - Else: working reg <= {reg[N-2:0], 1'b0}, count <= count + 1. Count increments by exactly 1 per shift.
- Count arithmetic:
  - Count is N bits wide. It can never exceed N-1 for nonzero input, so no wrap logic is needed.
  - A count beyond N-1 is unreachable and must not be guarded by extra logic.
- i_start during SHIFT: ignored (default build; see Configuration).
- i_reset during any state: next edge forces IDLE and clears all outputs and internal registers, regardless of i_start.
- i_reset and i_start high on the same edge: reset wins.

## Timing
- Reset values: o_busy=0, o_finished=0, o_value=0, o_count=0, o_zero=0.
- Define E0 as the edge on which i_start is sampled high. For a nonzero input with k leading zeros:
  - o_busy is high from after E0 through E(k+1).
  - o_finished rises after edge E(k+1), so latency is k+1 cycles.
  - Worst-case latency is N cycles, for input 1.
- Zero input: o_finished and o_zero rise after E1 (latency 1).
- An input with MSB already set: latency 1, o_count=0, o_value=i_value.
- Back-to-back operation: i_start may be asserted in the first DONE cycle. o_finished drops after that edge and o_busy rises.
- o_busy and o_finished are never high simultaneously.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- NORMALIZER_RESTART_EN:
  - Defined: i_start sampled high in SHIFT aborts the current operation. The block reloads i_value, clears count and stays in SHIFT; latency restarts from that edge.
  - Undefined: i_start in SHIFT is ignored, and the current operation completes unaffected.

## Structure
- Shared package holds:
  - state encoding constants for IDLE, SHIFT and DONE (2-bit);
  - a default-width constant equal to 8.
- The count increment reuses the codebase's existing Adder (N-bit, addend constant 1, carry unused) as the single sub-module instance.
- No other sub-module is needed.
- Shift, MSB detect and zero detect are inline logic.

## Test plan
- N=8, i_value=8'b0001_0110, pulse i_start -> o_busy for 4 cycles, then o_finished=1, o_value=8'b1011_0000, o_count=3, o_zero=0.
- i_value=8'h81 -> o_finished after 1 cycle, o_value=8'h81, o_count=0.
- i_value=8'h00 -> after 1 cycle: o_finished=1, o_zero=1, o_value=0, o_count=0.
- i_value=8'h01 -> o_finished after 8 cycles, o_value=8'h80, o_count=7; then in the first DONE cycle, start with 8'h40 -> o_count=1 after 2 cycles.
- Start 8'h01, assert i_reset after 3 cycles -> next cycle all outputs 0 and state IDLE; i_start held high together with i_reset is not accepted.
- Start 8'h01, then i_start with 8'h20 two cycles later:
  - Without NORMALIZER_RESTART_EN: o_count=7 at the original finish time.
  - With NORMALIZER_RESTART_EN: o_count=2, o_value=8'h80, finished 3 cycles after the second start.

Source files
------------

// File: rtl/normalizer_pkg.sv
// -----------------------------------------------------------------------------
// normalizer_pkg
//
// Shared definitions for the iterative left-normalizer.
//   - DEFAULT_N : default data width (also the width of the shift count).
//   - state_t   : 2-bit state encoding for the normalizer FSM
//                 (IDLE = reset state, SHIFT = normalizing, DONE = result valid).
// -----------------------------------------------------------------------------
package normalizer_pkg;

  localparam int DEFAULT_N = 8;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_SHIFT = 2'd1;
  localparam logic [1:0] STATE_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_SHIFT = STATE_SHIFT,
    ST_DONE  = STATE_DONE
  } state_t;

endpackage : normalizer_pkg

// File: rtl/normalizer_adder.sv
// -----------------------------------------------------------------------------
// normalizer_adder
//
// Plain W-bit ripple adder with carry in/out, the datapath's general-purpose
// adder. The normalizer uses it to step its shift count by one.
//
// Ports:
//   a    [W-1:0] in   first addend
//   b    [W-1:0] in   second addend
//   cin          in   carry in
//   sum  [W-1:0] out  a + b + cin (low W bits)
//   cout         out  carry out of the top bit
// -----------------------------------------------------------------------------
module normalizer_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full_sum;

  // Extend everything to W+1 bits so the carry lands in the top bit.
  assign full_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum      = full_sum[W-1:0];
  assign cout     = full_sum[W];

endmodule : normalizer_adder

// File: rtl/normalizer.sv
// -----------------------------------------------------------------------------
// normalizer
//
// Iterative left-normalizer. A value loaded with i_start is shifted left one
// bit per clock until its MSB is 1; the number of shifts taken (the
// leading-zero count) is reported alongside the normalized value. A zero input
// finishes after one cycle with o_zero set. Companion of the iterative shifter:
// same start/finished handshake, so a controller drives both identically.
//
// Handshake: i_start is sampled on every rising edge and is accepted in IDLE
// or DONE (i_value is captured on that same edge). o_busy is high while the
// block is working, o_finished is high from completion until the next
// accepted start or reset; the two are never high together. There is no
// back-pressure: a result is simply held until replaced.
//
// Build option:
//   NORMALIZER_RESTART_EN  when defined, i_start sampled high during SHIFT
//                          aborts the operation and reloads i_value; when
//                          undefined, i_start during SHIFT is ignored.
//
// Parameters:
//   N           data width and count width (N >= 2)
//
// Ports:
//   i_clock            in   clock, all state changes on rising edge
//   i_reset            in   synchronous active-high reset (wins over i_start)
//   i_start            in   load i_value and begin normalizing
//   i_value   [N-1:0]  in   value to normalize
//   o_busy             out  high while in SHIFT
//   o_finished         out  high while in DONE
//   o_value   [N-1:0]  out  normalized value (MSB set unless zero)
//   o_count   [N-1:0]  out  number of left shifts performed, 0..N-1
//   o_zero             out  high in DONE when the loaded value was 0
//   o_state   [1:0]    out  current FSM state (debug visibility)
//
// All outputs are registered; no combinational input-to-output path.
// -----------------------------------------------------------------------------
module normalizer
  import normalizer_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic [N-1:0] i_value,
  output logic         o_busy,
  output logic         o_finished,
  output logic [N-1:0] o_value,
  output logic [N-1:0] o_count,
  output logic         o_zero,
  output logic [1:0]   o_state
);

  state_t       state;
  logic [N-1:0] work;       // value being shifted
  logic [N-1:0] count;      // shifts performed so far
  logic [N-1:0] count_inc;  // count + 1
  logic         unused_carry;
  logic         restart;    // start accepted while already in SHIFT

  // Count never exceeds N-1 for a nonzero input, so the carry is never set
  // and no wrap handling is needed.
  normalizer_adder #(
    .W (N)
  ) u_count_adder (
    .a    (count),
    .b    (N'(1)),
    .cin  (1'b0),
    .sum  (count_inc),
    .cout (unused_carry)
  );

`ifdef NORMALIZER_RESTART_EN
  assign restart = i_start;
`else
  assign restart = 1'b0;
`endif

  assign o_state = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      work       <= '0;
      count      <= '0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      o_value    <= '0;
      o_count    <= '0;
      o_zero     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // DONE without a start holds the previous result untouched.
          if (i_start) begin
            state      <= ST_SHIFT;
            work       <= i_value;
            count      <= '0;
            o_zero     <= 1'b0;
            o_busy     <= 1'b1;
            o_finished <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (restart) begin
            // Abort and reload; latency counts again from this edge.
            work  <= i_value;
            count <= '0;
          end else if (work == '0) begin
            // Zero never acquires a leading one; report it without shifting.
            state      <= ST_DONE;
            o_zero     <= 1'b1;
            o_value    <= '0;
            o_count    <= '0;
            o_busy     <= 1'b0;
            o_finished <= 1'b1;
          end else if (work[N-1]) begin
            state      <= ST_DONE;
            o_value    <= work;
            o_count    <= count;
            o_busy     <= 1'b0;
            o_finished <= 1'b1;
          end else begin
            work  <= {work[N-2:0], 1'b0};
            count <= count_inc;
          end
        end

        default: begin
          state      <= ST_IDLE;
          o_busy     <= 1'b0;
          o_finished <= 1'b0;
        end
      endcase
    end
  end

endmodule : normalizer

// File: tb/tb_normalizer.sv
// -----------------------------------------------------------------------------
// tb_normalizer
//
// Self-checking bench for the normalizer (N = 8). Expected results come from a
// reference model that counts leading zeros directly from the input value.
// -----------------------------------------------------------------------------
module tb_normalizer;
  import normalizer_pkg::*;

  localparam int N       = 8;
  localparam int TIMEOUT = 2 * N + 4;

  // ---------------- clock / reset ----------------
  logic         i_clock = 1'b0;
  logic         i_reset;
  logic         i_start;
  logic [N-1:0] i_value;
  logic         o_busy;
  logic         o_finished;
  logic [N-1:0] o_value;
  logic [N-1:0] o_count;
  logic         o_zero;
  logic [1:0]   o_state;

  always #5 i_clock = ~i_clock;

  normalizer #(.N(N)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_value    (i_value),
    .o_busy     (o_busy),
    .o_finished (o_finished),
    .o_value    (o_value),
    .o_count    (o_count),
    .o_zero     (o_zero),
    .o_state    (o_state)
  );

  int n_vectors = 0;
  int n_miscompares = 0;

  // ---------------- reference model ----------------
  // Leading-zero count by scanning from the MSB; latency is one cycle per
  // shift plus the final cycle that observes the leading one.
  function automatic void model(input logic [N-1:0] v, output logic [N-1:0] ev,
                                output logic [N-1:0] ec, output logic ez,
                                output int elat);
    int lz;
    lz = 0;
    if (v == '0) begin
      ev = '0; ec = '0; ez = 1'b1; elat = 1;
      return;
    end
    while (v[N-1-lz] == 1'b0) lz++;
    ev   = v << lz;
    ec   = N'(lz);
    ez   = 1'b0;
    elat = lz + 1;
  endfunction

  // ---------------- driver ----------------
  // Starts an operation now and waits (bounded) for o_finished. Returns the
  // latency in cycles (-1 on timeout) and flags any cycle where busy/finished
  // were not exactly one-hot while the operation was in flight.
  task automatic do_op(input logic [N-1:0] v, output int lat, output logic bad_flags);
    int cyc;
    i_start = 1'b1;
    i_value = v;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    i_value = N'($urandom);
    bad_flags = 1'b0;
    cyc = 0;
    while (!o_finished && cyc < TIMEOUT) begin
      if (!o_busy) bad_flags = 1'b1;
      @(posedge i_clock); #1;
      cyc++;
    end
    if (o_busy && o_finished) bad_flags = 1'b1;
    lat = o_finished ? cyc : -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    i_start = 1'b1;
    i_value = 8'hFF;
    repeat (2) @(posedge i_clock);
    #1;
    n_vectors++;
    if ({o_busy, o_finished, o_value, o_count, o_zero} !== '0 || o_state !== ST_IDLE) begin
      n_miscompares++;
      $display("FAIL reset: busy=%b fin=%b val=%h cnt=%h zero=%b st=%0d want all 0, st=0",
               o_busy, o_finished, o_value, o_count, o_zero, o_state);
    end
    i_reset = 1'b0;
    i_start = 1'b0;
    @(posedge i_clock); #1;
    n_vectors++;
    if (o_state !== ST_IDLE || o_busy !== 1'b0) begin
      n_miscompares++;
      $display("FAIL idle_hold: st=%0d busy=%b want st=0 busy=0", o_state, o_busy);
    end
  endtask

  task automatic test_directed();
    logic [N-1:0] vals [4];
    logic [N-1:0] evs  [4];
    int           ecs  [4];
    logic         ezs  [4];
    int           lats [4];
    int           lat;
    logic         bad;
    vals = '{8'b0001_0110, 8'h81, 8'h00, 8'h01};
    evs  = '{8'b1011_0000, 8'h81, 8'h00, 8'h80};
    ecs  = '{3, 0, 0, 7};
    ezs  = '{1'b0, 1'b0, 1'b1, 1'b0};
    lats = '{4, 1, 1, 8};
    for (int i = 0; i < 4; i++) begin
      do_op(vals[i], lat, bad);
      n_vectors++;
      if (lat != lats[i] || bad) begin
        n_miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d flags_bad=%b want %0d", i, lat, bad, lats[i]);
      end
      n_vectors++;
      if (o_value !== evs[i] || o_count !== N'(ecs[i]) || o_zero !== ezs[i]) begin
        n_miscompares++;
        $display("FAIL directed_result[%0d]: val=%h cnt=%0d zero=%b want val=%h cnt=%0d zero=%b",
                 i, o_value, o_count, o_zero, evs[i], ecs[i], ezs[i]);
      end
    end
  endtask

  // Called while sitting in the first DONE cycle of the previous operation.
  task automatic test_back_to_back();
    int   lat;
    logic bad;
    do_op(8'h40, lat, bad);
    n_vectors++;
    if (lat != 2 || bad || o_count !== 8'd1 || o_value !== 8'h80) begin
      n_miscompares++;
      $display("FAIL back_to_back: lat=%0d bad=%b cnt=%0d val=%h want lat=2 bad=0 cnt=1 val=80",
               lat, bad, o_count, o_value);
    end
  endtask

  task automatic test_reset_mid_op();
    i_start = 1'b1;
    i_value = 8'h01;
    @(posedge i_clock); #1;          // E0
    i_start = 1'b0;
    repeat (2) @(posedge i_clock);   // E1, E2
    #1;
    i_reset = 1'b1;
    i_start = 1'b1;
    i_value = 8'h80;
    @(posedge i_clock); #1;          // E3: reset wins over start
    n_vectors++;
    if ({o_busy, o_finished, o_value, o_count, o_zero} !== '0 || o_state !== ST_IDLE) begin
      n_miscompares++;
      $display("FAIL reset_mid_op: busy=%b fin=%b val=%h cnt=%h zero=%b st=%0d want all 0, st=0",
               o_busy, o_finished, o_value, o_count, o_zero, o_state);
    end
    i_reset = 1'b0;
    i_start = 1'b0;
    @(posedge i_clock); #1;
    n_vectors++;
    if (o_state !== ST_IDLE || o_busy !== 1'b0) begin
      n_miscompares++;
      $display("FAIL reset_start_ignored: st=%0d busy=%b want st=0 busy=0", o_state, o_busy);
    end
  endtask

  task automatic test_start_during_shift();
    logic [N-1:0] ev, ec;
    logic         ez;
    int           elat, lat, l1;
    i_start = 1'b1;
    i_value = 8'h01;
    @(posedge i_clock); #1;          // E0
    i_start = 1'b0;
    @(posedge i_clock); #1;          // E1
    i_start = 1'b1;
    i_value = 8'h20;
    @(posedge i_clock); #1;          // E2: second start
    i_start = 1'b0;
    i_value = 8'h00;
`ifdef NORMALIZER_RESTART_EN
    model(8'h20, ev, ec, ez, l1);
    elat = 2 + l1;
`else
    model(8'h01, ev, ec, ez, l1);
    elat = l1;
`endif
    lat = 2;
    while (!o_finished && lat < TIMEOUT) begin
      @(posedge i_clock); #1;
      lat++;
    end
    if (!o_finished) lat = -1;
    n_vectors++;
    if (lat != elat || o_count !== ec || o_value !== ev || o_zero !== ez) begin
      n_miscompares++;
      $display("FAIL start_during_shift: lat=%0d cnt=%0d val=%h zero=%b want lat=%0d cnt=%0d val=%h zero=%b",
               lat, o_count, o_value, o_zero, elat, ec, ev, ez);
    end
  endtask

  task automatic test_random(input int iters);
    logic [N-1:0] v, ev, ec;
    logic         ez;
    int           elat, lat, gap;
    logic         bad;
    for (int i = 0; i < iters; i++) begin
      v = N'($urandom_range(0, 255) >> $urandom_range(0, 8));
      model(v, ev, ec, ez, elat);
      do_op(v, lat, bad);
      n_vectors++;
      if (lat != elat || bad) begin
        n_miscompares++;
        $display("FAIL random_latency: in=%h lat=%0d bad=%b want lat=%0d", v, lat, bad, elat);
      end
      n_vectors++;
      if (o_value !== ev || o_count !== ec || o_zero !== ez) begin
        n_miscompares++;
        $display("FAIL random_result: in=%h val=%h cnt=%0d zero=%b want val=%h cnt=%0d zero=%b",
                 v, o_value, o_count, o_zero, ev, ec, ez);
      end
      // Idle in DONE with a wandering i_value; the result must hold.
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        i_value = N'($urandom);
        @(posedge i_clock); #1;
      end
      if (gap > 0) begin
        n_vectors++;
        if (!o_finished || o_busy || o_value !== ev || o_count !== ec || o_zero !== ez) begin
          n_miscompares++;
          $display("FAIL done_hold: fin=%b busy=%b val=%h cnt=%0d zero=%b want fin=1 busy=0 val=%h cnt=%0d zero=%b",
                   o_finished, o_busy, o_value, o_count, o_zero, ev, ec, ez);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_value = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_op();
    test_start_during_shift();
    test_random(60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule : tb_normalizer
